data_sched: RTL and testbench

- Sequences feature-word reads that feed the data_in_reorder / fifo_data / data_gen input path in the clk_200M domain.
- Walks a layer's output pixels and input-channel groups, and issues 128-bit read requests to the feature buffer.
- Attaches per-word tags (layer_type, calc_en, acc_s, acc_para) that travel with the data into the reorder FIFO.
- Throttles on the FIFO write-side fill level so fifo_data never overflows.

---
 rtl/data_sched_pkg.sv | 43 ++++
 rtl/data_sched_cnt.sv | 57 +++++
 rtl/data_sched.sv | 154 +++++++++++++++
 tb/tb_data_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sched_pkg.sv
// Shared definitions for the feature-read path: layer types, tag layout and
// the scheduler state encoding. data_in_reorder and data_gen import this too.
package data_sched_pkg;

  typedef enum logic [2:0] {
    L_CONV  = 3'd0,
    L_DW    = 3'd1,
    L_PW    = 3'd2,
    L_AVGPL = 3'd3,
    L_PW_SC = 3'd4
  } layer_type_e;

  localparam int unsigned TAG_LT_W   = 7;
  localparam int unsigned TAG_PARA_W = 8;
  localparam int unsigned TAG_W      = TAG_LT_W + 2 + TAG_PARA_W;

  // Tag word as it is written into the reorder FIFO, MSB first.
  typedef struct packed {
    logic [TAG_LT_W-1:0]   layer_type;
    logic                  calc_en;
    logic                  acc_s;
    logic [TAG_PARA_W-1:0] acc_para;
  } tag_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } sched_state_e;

  function automatic tag_t tag_make(input logic [2:0] lt, input logic calc_en,
                                    input logic acc_s,
                                    input logic [TAG_PARA_W-1:0] acc_para);
    tag_t t;
    t.layer_type = {{(TAG_LT_W-3){1'b0}}, lt};
    t.calc_en    = calc_en;
    t.acc_s      = acc_s;
    t.acc_para   = acc_para;
    return t;
  endfunction

endpackage

// File: rtl/data_sched_cnt.sv
// Nested word / group / pixel counter for the feature-read walk, with the
// wrap flags the scheduler uses for tags and layer-end detection.
module data_sched_cnt
  import data_sched_pkg::*;
#(
  parameter int unsigned PIX_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [3:0]       words_i,
  input  logic [7:0]       grp_num_i,
  input  logic [PIX_W-1:0] pix_num_i,
  output logic             word_last_o,
  output logic             grp_first_o,
  output logic             all_last_o
);

  logic [3:0]       word_q;
  logic [7:0]       grp_q;
  logic [PIX_W-1:0] pix_q;
  logic             grp_last;
  logic             pix_last;

  assign word_last_o = (word_q == words_i - 4'd1);
  assign grp_last    = (grp_q == grp_num_i - 8'd1);
  assign pix_last    = (pix_q == pix_num_i - PIX_W'(1));
  assign grp_first_o = (grp_q == '0);
  assign all_last_o  = word_last_o & grp_last & pix_last;

  // Advance word, carry into group, carry into pixel on each accepted read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q <= '0;
      grp_q  <= '0;
      pix_q  <= '0;
    end else if (clr_i) begin
      word_q <= '0;
      grp_q  <= '0;
      pix_q  <= '0;
    end else if (adv_i) begin
      if (word_last_o) begin
        word_q <= '0;
        if (grp_last) begin
          grp_q <= '0;
          pix_q <= pix_q + PIX_W'(1);
        end else begin
          grp_q <= grp_q + 8'd1;
        end
      end else begin
        word_q <= word_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/data_sched.sv
// Feature-word read scheduler: walks pixels x groups x words, issues tagged
// read requests and throttles on the reorder FIFO fill level.
module data_sched
  import data_sched_pkg::*;
#(
  parameter int unsigned         ADDR_W  = 16,
  parameter int unsigned         PIX_W   = 16,
  parameter int unsigned         USEDW_W = 8,
  parameter logic [USEDW_W-1:0]  FIFO_HI = 8'd200
) (
  input  logic               clk_200M,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [2:0]         cfg_layer_type,
  input  logic [ADDR_W-1:0]  cfg_base_addr,
  input  logic [PIX_W-1:0]   cfg_pix_num,
  input  logic [7:0]         cfg_grp_num,
  input  logic [3:0]         cfg_words,
  input  logic [USEDW_W-1:0] fifo_wrusedw,
  output logic               rd_req,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic               rd_gnt,
  output logic [6:0]         tag_layer_type,
  output logic               tag_calc_en,
  output logic               tag_acc_s,
  output logic [7:0]         tag_acc_para,
  output logic               busy,
  output logic               done
);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        type_q, type_d;
  logic [PIX_W-1:0]  pix_num_q, pix_num_d;
  logic [7:0]        grp_num_q, grp_num_d;
  logic [3:0]        words_q, words_d;
  logic [7:0]        para_q, para_d;
  // Set while a request is on the bus awaiting its grant; the throttle is
  // only consulted when this is clear so a presented request never drops.
  logic              hold_q, hold_d;

  logic req, cnt_clr, cnt_adv;
  logic word_last, grp_first, all_last;
  logic fifo_hi;
  tag_t tag;

  assign fifo_hi = (fifo_wrusedw >= FIFO_HI);

  data_sched_cnt #(
    .PIX_W(PIX_W)
  ) u_cnt (
    .clk_i      (clk_200M),
    .rst_i      (rst),
    .clr_i      (cnt_clr),
    .adv_i      (cnt_adv),
    .words_i    (words_q),
    .grp_num_i  (grp_num_q),
    .pix_num_i  (pix_num_q),
    .word_last_o(word_last),
    .grp_first_o(grp_first),
    .all_last_o (all_last)
  );

  // State, address and latched configuration registers.
  always_ff @(posedge clk_200M or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      type_q    <= '0;
      pix_num_q <= '0;
      grp_num_q <= '0;
      words_q   <= '0;
      para_q    <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      type_q    <= type_d;
      pix_num_q <= pix_num_d;
      grp_num_q <= grp_num_d;
      words_q   <= words_d;
      para_q    <= para_d;
      hold_q    <= hold_d;
    end
  end

  // Next-state, request handshake and throttle decisions.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    type_d    = type_q;
    pix_num_d = pix_num_q;
    grp_num_d = grp_num_q;
    words_d   = words_q;
    para_d    = para_q;
    hold_d    = hold_q;
    req       = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_adv   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          type_d    = cfg_layer_type;
          pix_num_d = cfg_pix_num;
          grp_num_d = cfg_grp_num;
          words_d   = cfg_words;
          para_d    = cfg_grp_num - 8'd1;
          addr_d    = cfg_base_addr;
          hold_d    = 1'b0;
          cnt_clr   = 1'b1;
          if (cfg_pix_num == '0 || cfg_grp_num == '0 || cfg_words == '0)
            state_d = S_DONE;
          else
            state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!hold_q && fifo_hi) begin
          state_d = S_WAIT;
        end else begin
          req = 1'b1;
          if (rd_gnt) begin
            cnt_adv = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            hold_d  = 1'b0;
            if (all_last) state_d = S_DONE;
          end else begin
            hold_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!fifo_hi) state_d = S_RUN;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tag = tag_make(type_q, req & word_last, req & grp_first, para_q);

  assign rd_req         = req;
  assign rd_addr        = addr_q;
  assign busy           = (state_q != S_IDLE);
  assign tag_layer_type = tag.layer_type;
  assign tag_calc_en    = tag.calc_en;
  assign tag_acc_s      = tag.acc_s;
  assign tag_acc_para   = tag.acc_para;

endmodule

// File: tb/tb_data_sched.sv
// Directed bench for data_sched: walks, multi-word groups, backpressure,
// grant stall, zero config, ignored restart and mid-layer reset.
module tb_data_sched;

  logic        clk_200M = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [2:0]  cfg_layer_type;
  logic [15:0] cfg_base_addr;
  logic [15:0] cfg_pix_num;
  logic [7:0]  cfg_grp_num;
  logic [3:0]  cfg_words;
  logic [7:0]  fifo_wrusedw;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_gnt;
  logic [6:0]  tag_layer_type;
  logic        tag_calc_en;
  logic        tag_acc_s;
  logic [7:0]  tag_acc_para;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_ce[$];
  logic [31:0] q_as[$];
  logic [31:0] q_para[$];
  logic [31:0] q_type[$];
  int n_g, done_cyc, last_cyc;

  always #5 clk_200M = ~clk_200M;

  data_sched #(
    .ADDR_W (16),
    .PIX_W  (16),
    .USEDW_W(8),
    .FIFO_HI(8'd200)
  ) dut (
    .clk_200M      (clk_200M),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_layer_type(cfg_layer_type),
    .cfg_base_addr (cfg_base_addr),
    .cfg_pix_num   (cfg_pix_num),
    .cfg_grp_num   (cfg_grp_num),
    .cfg_words     (cfg_words),
    .fifo_wrusedw  (fifo_wrusedw),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .tag_layer_type(tag_layer_type),
    .tag_calc_en   (tag_calc_en),
    .tag_acc_s     (tag_acc_s),
    .tag_acc_para  (tag_acc_para),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_layer(input logic [2:0] t, input logic [15:0] base,
                             input logic [15:0] pix, input logic [7:0] grp,
                             input logic [3:0] words);
    @(negedge clk_200M);
    cfg_layer_type = t;
    cfg_base_addr  = base;
    cfg_pix_num    = pix;
    cfg_grp_num    = grp;
    cfg_words      = words;
    cfg_start      = 1'b1;
    rd_gnt         = 1'b0;
    fifo_wrusedw   = 8'd10;
    #2;
    chk("idle_busy", busy, 0);
    chk("idle_req", rd_req, 0);
  endtask

  // Run one layer to its done pulse, recording every grant. Optional
  // backpressure window after grant bp_after and grant stall at st_at.
  task automatic walk(input string name, input int bp_after, input int bp_len,
                      input int st_at, input int st_len);
    int cyc = 0;
    int bp_rem = 0;
    int st_rem = 0;
    bit st_used = 0;
    bit done_seen = 0;
    logic [31:0] s_addr, s_tags;
    q_addr.delete(); q_ce.delete(); q_as.delete(); q_para.delete(); q_type.delete();
    n_g = 0; done_cyc = -1; last_cyc = -1;
    while (!done_seen && cyc < 300) begin
      @(negedge clk_200M);
      cfg_start    = 1'b0;
      fifo_wrusedw = (bp_rem > 0) ? 8'd200 : ((st_rem > 0) ? 8'd255 : 8'd10);
      #1;
      if (!st_used && st_len > 0 && rd_req && n_g == st_at) begin
        st_used = 1; st_rem = st_len;
        s_addr = 32'(rd_addr);
        s_tags = 32'({tag_layer_type, tag_calc_en, tag_acc_s, tag_acc_para});
      end
      rd_gnt = (st_rem == 0);
      #1;
      if (st_rem > 0) begin
        chk({name, "_stall_req"}, rd_req, 1);
        chk({name, "_stall_addr"}, 32'(rd_addr), s_addr);
        chk({name, "_stall_tags"},
            32'({tag_layer_type, tag_calc_en, tag_acc_s, tag_acc_para}), s_tags);
        st_rem--;
      end else if (bp_rem > 0) begin
        chk({name, "_bp_noreq"}, rd_req, 0);
        bp_rem--;
      end
      if (done) begin
        done_seen = 1; done_cyc = cyc;
      end
      if (rd_req && rd_gnt) begin
        q_addr.push_back(32'(rd_addr));
        q_ce.push_back(32'(tag_calc_en));
        q_as.push_back(32'(tag_acc_s));
        q_para.push_back(32'(tag_acc_para));
        q_type.push_back(32'(tag_layer_type));
        n_g++; last_cyc = cyc;
        if (n_g == bp_after) bp_rem = bp_len;
      end
      cyc++;
    end
    if (!done_seen) chk({name, "_timeout"}, 0, 1);
    rd_gnt = 1'b0;
    chk({name, "_busy_at_done"}, busy, 1);
    @(negedge clk_200M);
    #2;
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_done_once"}, done, 0);
  endtask

  // Expected tags from the nested loop position of grant i.
  task automatic check_grants(input string name, input int n_exp, input int base,
                              input int para, input int typ, input int words,
                              input int grps);
    chk({name, "_ngrants"}, n_g, n_exp);
    for (int i = 0; i < n_exp && i < q_addr.size(); i++) begin
      int w, g;
      w = i % words;
      g = (i / words) % grps;
      chk($sformatf("%s_addr%0d", name, i), q_addr[i], (base + i) & 32'hFFFF);
      chk($sformatf("%s_ce%0d", name, i), q_ce[i], (w == words - 1) ? 1 : 0);
      chk($sformatf("%s_as%0d", name, i), q_as[i], (g == 0) ? 1 : 0);
      chk($sformatf("%s_para%0d", name, i), q_para[i], para);
      chk($sformatf("%s_type%0d", name, i), q_type[i], typ);
    end
    chk({name, "_done_cyc"}, done_cyc, last_cyc + 1);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_layer_type = '0; cfg_base_addr = '0;
    cfg_pix_num = '0; cfg_grp_num = '0; cfg_words = '0; fifo_wrusedw = '0;
    rd_gnt = 1'b0;
    repeat (2) @(negedge clk_200M);
    #2;
    chk("rst_req", rd_req, 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tags", 32'({tag_layer_type, tag_calc_en, tag_acc_s, tag_acc_para}), 0);
    @(negedge clk_200M);
    rst = 1'b0;

    // Basic walk: pw, 2 pixels x 3 groups x 1 word.
    start_layer(3'd2, 16'h0100, 16'd2, 8'd3, 4'd1);
    walk("basic", -1, 0, -1, 0);
    check_grants("basic", 6, 'h0100, 2, 2, 1, 3);

    // Multi-word conv: 1 pixel x 2 groups x 3 words.
    start_layer(3'd0, 16'h0200, 16'd1, 8'd2, 4'd3);
    walk("conv", -1, 0, -1, 0);
    check_grants("conv", 6, 'h0200, 1, 0, 3, 2);

    // Backpressure for 10 cycles after the 2nd grant.
    start_layer(3'd2, 16'h0300, 16'd1, 8'd6, 4'd1);
    walk("bp", 2, 10, -1, 0);
    check_grants("bp", 6, 'h0300, 5, 2, 1, 6);

    // Grant stall of 4 cycles on the 2nd request, FIFO jumps to 255.
    start_layer(3'd1, 16'h0400, 16'd1, 8'd2, 4'd2);
    walk("stall", -1, 0, 1, 4);
    check_grants("stall", 4, 'h0400, 1, 1, 2, 2);

    // Address wrap past the top of the word space.
    start_layer(3'd3, 16'hFFFE, 16'd1, 8'd1, 4'd4);
    walk("wrap", -1, 0, -1, 0);
    check_grants("wrap", 4, 'hFFFE, 0, 3, 4, 1);

    // Zero word count: straight to done, no requests.
    start_layer(3'd2, 16'h0600, 16'd4, 8'd4, 4'd0);
    walk("zero", -1, 0, -1, 0);
    check_grants("zero", 0, 'h0600, 3, 2, 1, 1);
    chk("zero_done_cyc", done_cyc, 0);

    // Restart while busy must not disturb the latched configuration.
    start_layer(3'd4, 16'h0500, 16'd1, 8'd1, 4'd2);
    @(negedge clk_200M);
    cfg_layer_type = 3'd3; cfg_base_addr = 16'h7000; cfg_pix_num = 16'd9;
    cfg_grp_num = 8'd5; cfg_words = 4'd7; cfg_start = 1'b1; rd_gnt = 1'b0;
    #2;
    chk("restart_busy", busy, 1);
    walk("restart", -1, 0, -1, 0);
    check_grants("restart", 2, 'h0500, 0, 4, 2, 1);

    // Reset while the 3rd of 6 grants is pending.
    start_layer(3'd2, 16'h0800, 16'd1, 8'd6, 4'd1);
    repeat (2) begin
      @(negedge clk_200M);
      cfg_start = 1'b0;
      rd_gnt = 1'b1;
    end
    @(negedge clk_200M);
    rd_gnt = 1'b0;
    #1;
    chk("rstmid_pre_req", rd_req, 1);
    chk("rstmid_pre_addr", 32'(rd_addr), 'h0802);
    rst = 1'b1;
    #1;
    chk("rstmid_req", rd_req, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    @(negedge clk_200M);
    rst = 1'b0;
    start_layer(3'd2, 16'h0800, 16'd1, 8'd6, 4'd1);
    walk("rstmid", -1, 0, -1, 0);
    check_grants("rstmid", 6, 'h0800, 5, 2, 1, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
